// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;
  localparam int NREQ   = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 3;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_t;

  function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] s);
    return NREQ'(1) << s;
  endfunction
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side and consumer-side signals of the arbiter, bundled as one bus.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][DATA_W-1:0] din;
  logic [NREQ-1:0]             gnt;
  logic [SEL_W-1:0]            sel;
  logic [DATA_W-1:0]           y;
  logic                        y_valid;
  logic                        y_ready;

  modport slave  (input  req, din, y_ready, output gnt, sel, y, y_valid);
  modport master (output req, din, y_ready, input  gnt, sel, y, y_valid);
endinterface

// File: rtl/mux8_rr_arbiter_mux8.sv
// The shared 8:1 word mux; purely combinational.
module mux8
  import mux8_arb_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [NREQ-1:0][W-1:0] d,
  input  logic [SEL_W-1:0]       s,
  output logic [W-1:0]           y
);
  assign y = d[s];
endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin pick: rotate eligible so ptr sits at bit 0, take the lowest set bit, rotate back.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NREQ-1:0]  eligible,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);
  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] idx;

  always_comb begin
    rot = NREQ'({eligible, eligible} >> ptr);
    idx = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (rot[i]) idx = SEL_W'(i);
    winner = idx + ptr;
    any    = |eligible;
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux; the winning word is registered behind a valid/ready output.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int RR_RESET_PTR = 0,
  parameter int DATA_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8_rr_arbiter_if.slave  bus
);
  arb_state_t        state;
  logic [SEL_W-1:0]  ptr, sel_q, winner;
  logic [DATA_W-1:0] y_q, mux_y;
  logic [NREQ-1:0]   gnt_q, eligible;
  logic              any, load;

  // Last cycle's grantee is masked so a still-high req is not taken twice.
  assign eligible = bus.req & ~gnt_q;
  assign load     = ((state == EMPTY) || bus.y_ready) && any;

  rr_pick8 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner),
    .any      (any)
  );

  mux8 #(.W(DATA_W)) u_mux (
    .d (bus.din),
    .s (winner),
    .y (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr   <= SEL_W'(RR_RESET_PTR);
      sel_q <= '0;
      y_q   <= '0;
      gnt_q <= '0;
    end else begin
      gnt_q <= '0;
      if (load) begin
        state <= FULL;
        sel_q <= winner;
        y_q   <= mux_y;
        gnt_q <= onehot8(winner);
        ptr   <= winner + SEL_W'(1);
      end else if (state == FULL && bus.y_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.y_valid = (state == FULL);
  assign bus.y       = y_q;
  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: vector table through a scoreboard queue, plus reset and fairness sequences.
module tb_mux8_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux8_rr_arbiter_if bus();
  mux8_rr_arbiter #(.RR_RESET_PTR(0), .DATA_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef logic [7:0][2:0] din_t;
  typedef struct {
    logic       pre_rst;
    logic [7:0] req;
    din_t       din;
    logic       rdy;
    logic       vld;
    logic [2:0] y;
    logic [2:0] sel;
    logic [7:0] gnt;
  } vec_t;
  typedef struct {logic vld; logic [2:0] y; logic [2:0] sel; logic [7:0] gnt;} exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  din_t dA, dB;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic pr, input logic [7:0] rq, input din_t d, input logic rd,
                     input logic v, input logic [2:0] yy, input logic [2:0] s, input logic [7:0] g);
    vec_t t;
    t.pre_rst = pr; t.req = rq; t.din = d; t.rdy = rd;
    t.vld = v; t.y = yy; t.sel = s; t.gnt = g;
    tv.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cnt[8];
    int   viol;
    logic [7:0] prev;

    for (int i = 0; i < 8; i++) dA[i] = 3'(i);
    dB = dA; dB[3] = 3'b101;

    // Reset held with everyone requesting
    rst_n = 1'b0; bus.req = 8'hFF; bus.din = dA; bus.y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y", 32'(bus.y), 0); chk("rst.vld", 32'(bus.y_valid), 0);
    chk("rst.sel", 32'(bus.sel), 0); chk("rst.gnt", 32'(bus.gnt), 0);
    @(negedge clk); bus.req = 8'h00; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d.vld", i), 32'(bus.y_valid), 0);
    end

    // Lone requester: grant, bubble, grant
    add(0, 8'h08, dB, 1, 1, 5, 3, 8'h08);
    add(0, 8'h08, dB, 1, 0, 5, 3, 8'h00);
    add(0, 8'h08, dB, 1, 1, 5, 3, 8'h08);
    add(0, 8'h00, dB, 1, 0, 5, 3, 8'h00);
    // Full round robin from a fresh reset, through y=2
    for (int k = 0; k <= 10; k++)
      add(k == 0, 8'hFF, dA, 1, 1, 3'(k % 8), 3'(k % 8), 8'(1) << (k % 8));
    // Backpressure holds y=2
    for (int k = 0; k < 5; k++) add(0, 8'hFF, dA, 0, 1, 2, 2, 8'h00);
    add(0, 8'hFF, dA, 1, 1, 3, 3, 8'h08);
    add(0, 8'hFF, dA, 1, 1, 4, 4, 8'h10);
    add(0, 8'hFF, dA, 1, 1, 5, 5, 8'h20);
    // Wrap past absent 6,7
    add(0, 8'h03, dA, 1, 1, 0, 0, 8'h01);
    add(0, 8'h03, dA, 1, 1, 1, 1, 8'h02);
    add(0, 8'h03, dA, 1, 1, 0, 0, 8'h01);
    add(0, 8'h00, dA, 1, 0, 0, 0, 8'h00);

    foreach (tv[i]) begin
      @(negedge clk);
      if (tv[i].pre_rst) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
      end
      bus.req = tv[i].req; bus.din = tv[i].din; bus.y_ready = tv[i].rdy;
      sb.push_back('{tv[i].vld, tv[i].y, tv[i].sel, tv[i].gnt});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.vld", i), 32'(bus.y_valid), 32'(e.vld));
      chk($sformatf("v%0d.y",   i), 32'(bus.y),       32'(e.y));
      chk($sformatf("v%0d.sel", i), 32'(bus.sel),     32'(e.sel));
      chk($sformatf("v%0d.gnt", i), 32'(bus.gnt),     32'(e.gnt));
    end

    // Async reset while FULL and stalled; ptr was 1 so winner is 1
    @(negedge clk); bus.req = 8'hFF; bus.y_ready = 1'b0;
    @(posedge clk); #1;
    chk("ar.load.gnt", 32'(bus.gnt), 32'h02); chk("ar.load.y", 32'(bus.y), 1);
    #2 rst_n = 1'b0; #1;
    chk("ar.vld", 32'(bus.y_valid), 0); chk("ar.gnt", 32'(bus.gnt), 0);
    chk("ar.y", 32'(bus.y), 0);
    @(negedge clk); rst_n = 1'b1; bus.y_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar.post0.gnt", 32'(bus.gnt), 32'h01); chk("ar.post0.y", 32'(bus.y), 0);
    chk("ar.post0.vld", 32'(bus.y_valid), 1);
    @(posedge clk); #1;
    chk("ar.post1.gnt", 32'(bus.gnt), 32'h02); chk("ar.post1.sel", 32'(bus.sel), 1);

    // Fairness over 16 loads with all requesting
    foreach (cnt[j]) cnt[j] = 0;
    viol = 0; prev = bus.gnt;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (!$onehot(bus.gnt) || (bus.gnt & prev) != 0 || !bus.y_valid) viol++;
      for (int j = 0; j < 8; j++) if (bus.gnt[j]) cnt[j]++;
      prev = bus.gnt;
    end
    chk("fair.viol", 32'(viol), 0);
    for (int j = 0; j < 8; j++) chk($sformatf("fair.cnt%0d", j), 32'(cnt[j]), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

- Shares one 8:1, 3-bit mux between eight independent requesters using round-robin arbitration.
- Drives the mux select, registers the selected word, and presents it downstream with a valid/ready handshake.
- Returns a one-cycle grant pulse to the requester whose word was taken.
- Sits between the eight producers and the single consumer of the mux output.

## Interface
- RR_RESET_PTR, 0: priority pointer value after reset (0..7); requester at this index has highest priority first.
- DATA_W, 3: word width; fixed at 3 to match the mux datapath.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  per-requester request; req[i] must hold with its data until gnt[i] pulses.
- din  in  8*DATA_W  packed requester data; requester i occupies din[i*3 +: 3].
- sel  out  3  index of last winner; drives the mux select.
- y  out  DATA_W  registered selected word.
- y_valid  out  1  y holds an unconsumed word.
- y_ready  in  1  downstream accepts y when y_valid && y_ready.
- gnt  out  8  one-hot, one-cycle pulse: the word of requester i was loaded into y at the previous edge.

## Operation
- **Reset values:** y=0, y_valid=0, sel=0, gnt=0, ptr=RR_RESET_PTR.
- **Eligibility:** eligible = req & ~gnt. The requester granted last cycle is masked, so its still-high req is not taken twice.
- **Load condition:** load = (!y_valid || y_ready) && |eligible.
- **Winner:** first set bit of eligible, scanning ptr, ptr+1, … with wrap 7→0. Index arithmetic is 3-bit modulo 8.
- **On load:**
  - sel <= winner.
  - y <= din word of winner, via the mux with select = winner combinationally.
  - y_valid <= 1.
  - gnt <= onehot(winner).
  - ptr <= winner+1 (mod 8).
- **Drain:** if y_valid && y_ready && !|eligible, then y_valid <= 0. y and sel hold their last values; gnt <= 0.
- **Stall:** if y_valid && !y_ready, then y, sel, y_valid and ptr all hold, and gnt <= 0.
- **State:** two states, EMPTY (y_valid=0) and FULL (y_valid=1).
  - EMPTY→FULL on load.
  - FULL→FULL on load, or while stalled.
  - FULL→EMPTY on drain.
- **Requester protocol:**
  - A requester may withdraw req before its gnt; it is then simply not considered.
  - Data change while req is held without gnt is undefined for that requester.
- y_ready while y_valid=0 is ignored.
- **Reset mid-operation:** asserting rst_n low immediately clears y_valid and gnt, and returns ptr to RR_RESET_PTR. Any held word is discarded. Requesters re-request after reset.

## Timing
- **Latency:** req[i] high at edge k with the load condition true, and i the winner → y/y_valid/sel valid and gnt[i]=1 after edge k (a one-cycle registered path).
- **Throughput:**
  - One word per cycle while y_ready=1 and at least two requesters are active.
  - A lone requester holding req gets one grant every 2 cycles, because of the gnt mask.
- **Simultaneous handshake and load:** the consumed word is replaced by the new winner at the same edge, with no bubble.
- **Fairness:** with all eight requesting continuously, each is served exactly once per 8 loads.
- gnt is never high for more than one consecutive cycle for the same index.
- gnt is never high in a cycle without a preceding load edge.

## Structure
- **Package mux8_arb_pkg:**
  - Constants NREQ=8, SEL_W=3, DATA_W=3.
  - State enum {EMPTY, FULL}.
  - Function onehot8(sel).
- **Sub-module rr_pick8** (combinational): inputs eligible[7:0] and ptr[2:0]; outputs winner[2:0] and any. It implements the rotate, priority-encode and unrotate steps.
- **Datapath:** the existing 8:1 three-bit mux, instantiated once and fed by the din slices, with select = the winner.
- All registers live in the top level.

## Test plan
- **Reset:** hold rst_n=0 with req=8'hFF → y=0, y_valid=0, sel=0, gnt=0. Release with req=0 for 10 cycles → y_valid stays 0.
- **Single requester:** req=8'h08, din slice 3 = 3'b101, y_ready=1.
  - After the first edge: y=5, sel=3, y_valid=1, gnt=8'h08.
  - Next cycle: gnt=0 and y_valid drops.
  - Following cycle: granted again.
- **Full round-robin:** req=8'hFF, din slice i = i, y_ready=1, RR_RESET_PTR=0 → y sequence 0,1,2,…,7,0 on consecutive cycles, with gnt following 8'h01, 8'h02, …, 8'h80, 8'h01.
- **Backpressure:** y_valid=1, y=2, y_ready=0 for 5 cycles with req=8'hFF → y, sel, y_valid stable, gnt=0. Raise y_ready → the next index loads at the same edge.
- **Wrap:** after a grant to requester 5 (ptr=6), req=8'h03 → grant 0, then 1. Requesters 6 and 7 absent; no stall.
- **Async reset mid-stall:** FULL with y_ready=0, pull rst_n low between edges → y_valid=0 and gnt=0 immediately. After release, the first grant follows RR_RESET_PTR.
